// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit
// positions, the hex-to-segment ROM and the nibble decode helper.
package seg7_pkg;

    // Bit positions inside the 8-bit segment word (a is the MSB, dp the LSB)
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-high a..g patterns for hex digits 0..F
    localparam logic [6:0] SEG_ROM [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Hex nibble to active-high a..g pattern
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        return SEG_ROM[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timing for the seven-segment driver: per-slot prescaler, gap/on
// phase, current digit index and the end-of-frame pulse.
module seg7_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4096,
    parameter int GAP_CYCLES = 16,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             phase_on,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             frame_done_r;

    // Prescaler wrap advances the digit index; frame_done is set one cycle
    // early so that it is high exactly during the last cycle of the last slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= '0;
            idx_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= (cnt_r == CNT_PRE) && (idx_r == IDX_LAST);
            if (cnt_r == CNT_MAX) begin
                cnt_r <= '0;
                if (idx_r == IDX_LAST) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign idx        = idx_r;
    assign phase_on   = (cnt_r >= CNT_GAP);
    assign frame_done = frame_done_r;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver. Double-buffers the digit
// data (pending/active), decodes the scanned digit and registers seg/way.
// Optional build macro LEADING_ZERO_BLANK_EN: auto-blank leading zeros of
// the active buffer (stops at the first nonzero digit or a digit with dp).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 4096,
    parameter int GAP_CYCLES     = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int WAY_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digit_val,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   way,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] WAY_INV = (WAY_ACTIVE_LOW != 0) ? '1 : '0;

    logic [IDX_W-1:0]        idx_s;
    logic                    phase_on_s;

    logic [4*NUM_DIGITS-1:0] pend_val_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic [NUM_DIGITS-1:0]   pend_blank_r;
    logic                    pend_valid_r;
    logic [4*NUM_DIGITS-1:0] act_val_r;
    logic [NUM_DIGITS-1:0]   act_dp_r;
    logic [NUM_DIGITS-1:0]   act_blank_r;

    logic [NUM_DIGITS-1:0]   lz_blank_s;
    logic [3:0]              nib_s;
    logic                    dark_s;
    logic [7:0]              pat_s;
    logic [NUM_DIGITS-1:0]   way_on_s;
    logic [7:0]              seg_r;
    logic [NUM_DIGITS-1:0]   way_r;

    seg7_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx_s),
        .phase_on   (phase_on_s),
        .frame_done (frame_done)
    );

    // Pending/active double buffer; a load on the copy cycle keeps pending valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val_r   <= '0;
            pend_dp_r    <= '0;
            pend_blank_r <= '1;
            pend_valid_r <= 1'b0;
            act_val_r    <= '0;
            act_dp_r     <= '0;
            act_blank_r  <= '1;
        end else begin
            if (frame_done && pend_valid_r) begin
                act_val_r   <= pend_val_r;
                act_dp_r    <= pend_dp_r;
                act_blank_r <= pend_blank_r;
            end
            if (load) begin
                pend_val_r   <= digit_val;
                pend_dp_r    <= dp_in;
                pend_blank_r <= blank_in;
                pend_valid_r <= 1'b1;
            end else if (frame_done) begin
                pend_valid_r <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank zeros from the top digit down until a nonzero digit or a lit dp
    always_comb begin
        logic run_v;
        lz_blank_s = '0;
        run_v      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (run_v && (act_val_r[4*i +: 4] == 4'h0) && !act_dp_r[i]) begin
                lz_blank_s[i] = 1'b1;
            end else begin
                run_v = 1'b0;
            end
        end
    end
`else
    assign lz_blank_s = '0;
`endif

    assign nib_s  = act_val_r[4*int'(idx_s) +: 4];
    assign dark_s = act_blank_r[idx_s] | lz_blank_s[idx_s];

    // Active-high segment pattern and digit enable for the current slot
    always_comb begin
        pat_s    = 8'h00;
        way_on_s = '0;
        if (phase_on_s) begin
            way_on_s[idx_s] = 1'b1;
            if (!dark_s) begin
                pat_s[SEG_A:SEG_G] = seg7_decode(nib_s);
                pat_s[SEG_DP]      = act_dp_r[idx_s];
            end else begin
                pat_s = 8'h00;
            end
        end else begin
            way_on_s = '0;
        end
    end

    // Output registers with polarity applied last; reset drives everything off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= SEG_INV;
            way_r <= WAY_INV;
        end else begin
            seg_r <= pat_s ^ SEG_INV;
            way_r <= way_on_s ^ WAY_INV;
        end
    end

    assign seg = seg_r;
    assign way = way_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver (4 digits, 8-cycle
// slots with a 2-cycle gap, active-low segments). Honours the build macro
// LEADING_ZERO_BLANK_EN in its expected values.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digit_val;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [7:0]  seg;
    logic [3:0]  way;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][7:0] exp_seg;   // expected on-phase seg per digit, [3]=digit 3
    } vec_t;

    vec_t vecs [6];

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (8),
        .GAP_CYCLES     (2),
        .SEG_ACTIVE_LOW (1),
        .WAY_ACTIVE_LOW (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_val  (digit_val),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .seg        (seg),
        .way        (way),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) at negedges until frame_done is observed high
    task automatic wait_fd();
        int n = 0;
        while (frame_done !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                check("frame_done timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    // Starting at a negedge with frame_done high, check one whole frame.
    // After m posedges the outputs reflect scan position m-2.
    task automatic check_frame(input int ei, input bit do_load, input int li);
        int p;
        int slot;
        int c;
        for (int m = 1; m <= 32; m++) begin
            @(negedge clk);
            if (do_load && m == 10) begin
                digit_val = vecs[li].val;
                dp_in     = vecs[li].dp;
                blank_in  = vecs[li].blank;
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (m >= 2) begin
                p    = m - 2;
                slot = p / 8;
                c    = p % 8;
                if (c == 0) begin
                    check($sformatf("v%0d gap seg d%0d", ei, slot), {24'd0, seg}, 32'h0000_00FF);
                    check($sformatf("v%0d gap way d%0d", ei, slot), {28'd0, way}, 32'd0);
                end
                if (c == 3) begin
                    check($sformatf("v%0d on seg d%0d", ei, slot), {24'd0, seg}, {24'd0, vecs[ei].exp_seg[slot]});
                    check($sformatf("v%0d on way d%0d", ei, slot), {28'd0, way}, 32'd1 << slot);
                end
            end
            if (m == 16) check($sformatf("v%0d fd mid-frame", ei), {31'd0, frame_done}, 32'd0);
        end
        check($sformatf("v%0d fd period", ei), {31'd0, frame_done}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0100, 4'b0000, {8'h9F, 8'h24, 8'h0D, 8'h99}};
        vecs[1] = '{16'hABCD, 4'b0000, 4'b0000, {8'h11, 8'hC1, 8'h63, 8'h85}};
        vecs[2] = '{16'h5678, 4'b1111, 4'b1010, {8'hFF, 8'h40, 8'hFF, 8'h00}};
        vecs[3] = '{16'h9EF0, 4'b0001, 4'b0000, {8'h09, 8'h61, 8'h71, 8'h02}};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[4] = '{16'h0050, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'h49, 8'h03}};
        vecs[5] = '{16'h0000, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
`else
        vecs[4] = '{16'h0050, 4'b0000, 4'b0000, {8'h03, 8'h03, 8'h49, 8'h03}};
        vecs[5] = '{16'h0000, 4'b0000, 4'b0000, {8'h03, 8'h03, 8'h03, 8'h03}};
`endif

        rst       = 1'b1;
        digit_val = 16'h0000;
        dp_in     = 4'b0000;
        blank_in  = 4'b0000;
        load      = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset seg", {24'd0, seg}, 32'h0000_00FF);
        check("reset way", {28'd0, way}, 32'd0);
        check("reset fd",  {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset seg", {24'd0, seg}, 32'h0000_00FF);
        check("post-reset way", {28'd0, way}, 32'd0);

        // First load, shown from the frame after the next frame_done
        @(negedge clk);
        digit_val = vecs[0].val;
        dp_in     = vecs[0].dp;
        blank_in  = vecs[0].blank;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd();

        // Each frame shows its vector while the next one is loaded mid-frame
        for (int i = 0; i < 6; i++) begin
            check_frame(i, 1'b1, (i < 5) ? i + 1 : 3);
        end

        // Load on the frame_done cycle: old pending shown next, new one after
        digit_val = vecs[0].val;
        dp_in     = vecs[0].dp;
        blank_in  = vecs[0].blank;
        load      = 1'b1;
        check_frame(3, 1'b0, 0);
        check_frame(0, 1'b0, 0);

        // Asynchronous reset in the middle of digit 0's on phase
        repeat (5) @(negedge clk);
        check("pre-reset on seg", {24'd0, seg}, 32'h0000_0099);
        check("pre-reset on way", {28'd0, way}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset seg", {24'd0, seg}, 32'h0000_00FF);
        check("async reset way", {28'd0, way}, 32'd0);
        check("async reset fd",  {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int m = 1; m <= 31; m++) begin
            @(negedge clk);
            if (m == 1) begin
                check("restart gap seg", {24'd0, seg}, 32'h0000_00FF);
                check("restart gap way", {28'd0, way}, 32'd0);
            end
            if (m == 4) begin
                check("restart d0 way", {28'd0, way}, 32'd1);
                check("restart d0 seg blank", {24'd0, seg}, 32'h0000_00FF);
            end
            if (m == 12) begin
                check("restart d1 way", {28'd0, way}, 32'd2);
                check("restart d1 seg blank", {24'd0, seg}, 32'h0000_00FF);
            end
            if (m == 20) check("restart fd low", {31'd0, frame_done}, 32'd0);
        end
        check("restart fd timing", {31'd0, frame_done}, 32'd1);

        // No pending data after reset: next frame stays blank
        repeat (4) @(negedge clk);
        check("cleared d0 way", {28'd0, way}, 32'd1);
        check("cleared d0 seg", {24'd0, seg}, 32'h0000_00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
